// File: rtl/control_multiciclo.sv
// -----------------------------------------------------------------------------
// control_multiciclo
// Multi-cycle controller for a small MIPS R-type datapath. One instruction is
// taken through IDLE -> DECODE -> READ -> EXEC -> WRITE, so a new word can be
// accepted every five cycles.
//
// Parameters
//   DATA_W          register data width
//   ADDR_W          register address width
// Ports
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   instruction     R-type word (opcode, rs, rt, rd, funct)
//   instr_valid     instruction present
//   instr_ready     high only in IDLE; acceptance = instr_valid & instr_ready
//   data_register_1 register bank read data for rs
//   data_register_2 register bank read data for rt
//   read_address_1  rs address, held from DECODE through WRITE
//   read_address_2  rt address, held from DECODE through WRITE
//   write_address   rd address for the write-back
//   data_write      write-back data
//   write_enable    one-cycle write strobe in WRITE (suppressed when rd = 0)
//   illegal         one-cycle pulse in DECODE for an unsupported word
//   retired_count   16-bit count of WRITE-state cycles (PERF_COUNT_EN only)
//
// Optional feature: define PERF_COUNT_EN to add the retired_count port.
// -----------------------------------------------------------------------------
module control_multiciclo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instruction,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] data_register_1,
   input  logic [DATA_W-1:0] data_register_2,
   output logic [ADDR_W-1:0] read_address_1,
   output logic [ADDR_W-1:0] read_address_2,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] data_write,
   output logic              write_enable,
   output logic              illegal
`ifdef PERF_COUNT_EN
   ,
   output logic [15:0]       retired_count
`endif
);

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      READ,
      EXEC,
      WRITE
   } state_t;

   state_t            state;
   logic [4:0]        instr_rd;
   logic [5:0]        instr_funct;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] result;

   // The shift-amount field has no meaning for the supported operations.
   logic unused_shamt;
   assign unused_shamt = ^instruction[10:6];

   // The result register is the write-back data path.
   assign data_write = result;

   function automatic logic is_legal(input logic [31:0] word);
      logic funct_ok;
      funct_ok = (word[5:0] == FUNCT_ADD) || (word[5:0] == FUNCT_SUB) ||
                 (word[5:0] == FUNCT_AND) || (word[5:0] == FUNCT_OR)  ||
                 (word[5:0] == FUNCT_SLT);
      return (word[31:26] == 6'd0) && funct_ok;
   endfunction

   function automatic logic [DATA_W-1:0] alu(input logic [5:0]        funct,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      case (funct)
         FUNCT_ADD: r = a + b;
         FUNCT_SUB: r = a - b;
         FUNCT_AND: r = a & b;
         FUNCT_OR:  r = a | b;
         FUNCT_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default:   r = '0;
      endcase
      return r;
   endfunction

   // Legality is judged on the acceptance edge so the illegal pulse is
   // already registered while the FSM sits in DECODE; DECODE then only has
   // to look at that flag to decide between READ and the return to IDLE.
   // write_enable is set on the EXEC->WRITE edge so the bank samples it on
   // the edge four cycles after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         instr_ready    <= 1'b1;
         instr_rd       <= '0;
         instr_funct    <= '0;
         op_a           <= '0;
         op_b           <= '0;
         result         <= '0;
         read_address_1 <= '0;
         read_address_2 <= '0;
         write_address  <= '0;
         write_enable   <= 1'b0;
         illegal        <= 1'b0;
`ifdef PERF_COUNT_EN
         retired_count  <= '0;
`endif
      end else begin
         write_enable <= 1'b0;
         illegal      <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  instr_rd       <= instruction[15:11];
                  instr_funct    <= instruction[5:0];
                  read_address_1 <= ADDR_W'(instruction[25:21]);
                  read_address_2 <= ADDR_W'(instruction[20:16]);
                  illegal        <= !is_legal(instruction);
                  instr_ready    <= 1'b0;
                  state          <= DECODE;
               end
            end
            DECODE: begin
               if (illegal) begin
                  instr_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  state <= READ;
               end
            end
            READ: begin
               op_a  <= data_register_1;
               op_b  <= data_register_2;
               state <= EXEC;
            end
            EXEC: begin
               result        <= alu(instr_funct, op_a, op_b);
               write_address <= ADDR_W'(instr_rd);
               write_enable  <= (instr_rd != 5'd0);
               state         <= WRITE;
            end
            WRITE: begin
               instr_ready <= 1'b1;
               state       <= IDLE;
`ifdef PERF_COUNT_EN
               retired_count <= retired_count + 16'd1;
`endif
            end
            default: begin
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_control_multiciclo
// Self-checking bench for control_multiciclo. A small register-bank model
// feeds the read ports; every accepted instruction pushes its expected
// write-back (address, data, cycle) onto a scoreboard that a monitor pops
// whenever write_enable is seen high.
// -----------------------------------------------------------------------------
module tb_control_multiciclo;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [31:0] JUNK_WORD = 32'h00224820;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       instruction;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] data_register_1;
   logic [DATA_W-1:0] data_register_2;
   logic [ADDR_W-1:0] read_address_1;
   logic [ADDR_W-1:0] read_address_2;
   logic [ADDR_W-1:0] write_address;
   logic [DATA_W-1:0] data_write;
   logic              write_enable;
   logic              illegal;
`ifdef PERF_COUNT_EN
   logic [15:0]       retired_count;
`endif

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        popped;
   logic [31:0] regs [32];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          retired_model = 0;
   int          last_accept = -100;

   control_multiciclo #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instruction    (instruction),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .data_register_1(data_register_1),
      .data_register_2(data_register_2),
      .read_address_1 (read_address_1),
      .read_address_2 (read_address_2),
      .write_address  (write_address),
      .data_write     (data_write),
      .write_enable   (write_enable),
      .illegal        (illegal)
`ifdef PERF_COUNT_EN
      ,
      .retired_count  (retired_count)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle counter used to measure write-back latency.
   always @(posedge clk) cyc <= cyc + 1;

   // The register bank model answers the two read addresses combinationally.
   assign data_register_1 = regs[read_address_1];
   assign data_register_2 = regs[read_address_2];

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference behaviour of one R-type word against the bank model.
   function automatic void modelInstr(input logic [31:0] w, output bit legal,
                                      output logic [31:0] r);
      logic [31:0] a;
      logic [31:0] b;
      a = regs[w[25:21]];
      b = regs[w[20:16]];
      legal = 1'b1;
      r = 32'd0;
      if (w[31:26] != 6'd0) legal = 1'b0;
      case (w[5:0])
         6'h20:   r = a + b;
         6'h22:   r = a - b;
         6'h24:   r = a & b;
         6'h25:   r = a | b;
         6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: legal = 1'b0;
      endcase
   endfunction

   // Monitor: every write strobe must match the oldest scoreboard entry,
   // including the cycle at which it appears.
   always @(negedge clk) begin
      if (write_enable === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_we", 32'd1, 32'd0);
         end else begin
            popped = sb.pop_front();
            checkOutput("wr_addr", 32'(write_address), 32'(popped.addr));
            checkOutput("wr_data", data_write, popped.data);
            checkOutput("wr_latency", cyc, popped.cyc);
         end
      end
   end

   // Presents one word, waits (bounded) for acceptance and records the
   // expected write-back. keep_valid leaves instr_valid high with a junk word
   // that the busy controller has to ignore.
   task automatic applyStimulus(input logic [31:0] word, input bit keep_valid,
                                input bit check_gap);
      int          n;
      bit          legal;
      logic [31:0] r;
      @(posedge clk); #1;
      instruction = word;
      instr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (instr_ready !== 1'b1) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         instr_valid = 1'b0;
         return;
      end
      if (check_gap) checkOutput("b2b_gap", cyc + 1 - last_accept, 32'd5);
      last_accept = cyc + 1;
      modelInstr(word, legal, r);
      if (legal) begin
         retired_model++;
         if (word[15:11] != 5'd0) sb.push_back('{addr: word[15:11], data: r, cyc: cyc + 4});
      end
      @(posedge clk); #1;
      if (keep_valid) begin
         instruction = JUNK_WORD;
      end else begin
         instr_valid = 1'b0;
         instruction = $urandom;
      end
   endtask

   // Bounded wait until every expected write-back has been observed.
   task automatic waitDrain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checkOutput("drain_timeout", sb.size(), 32'd0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic checkRetired(input string tag);
`ifdef PERF_COUNT_EN
      checkOutput(tag, 32'(retired_count), 32'(retired_model & 16'hFFFF));
`else
      if (tag.len() == 0) $display("[TB] empty tag");
`endif
   endtask

   logic [31:0] words [4];
   logic [31:0] illegal_words [2];

   // Main sequence: reset, each ALU function, illegal words, rd = 0,
   // reset during EXEC, then a back-to-back burst.
   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instruction = 32'd0;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;

      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(instr_ready), 32'd1);
      checkOutput("rst_we", 32'(write_enable), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_wdata", data_write, 32'd0);
      checkOutput("rst_raddr1", 32'(read_address_1), 32'd0);
      checkRetired("rst_retired");
      @(posedge clk); #1;
      rst_n = 1'b1;

      regs[1] = 32'd5;
      regs[2] = 32'd7;
      applyStimulus(32'h00221820, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(32'h00222022, 1'b0, 1'b0);
      waitDrain();

      regs[1] = 32'hFFFF_FFFF;
      regs[2] = 32'd1;
      applyStimulus(32'h0022282A, 1'b0, 1'b0);
      waitDrain();
      regs[1] = 32'd1;
      regs[2] = 32'hFFFF_FFFF;
      applyStimulus(32'h0022282A, 1'b0, 1'b0);
      waitDrain();

      regs[1] = 32'hF0F0_3C3C;
      regs[2] = 32'h0FF0_A5A5;
      applyStimulus(32'h00223824, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(32'h00224025, 1'b0, 1'b0);
      waitDrain();
      checkRetired("retired_alu");

      illegal_words[0] = 32'h8C220000;
      illegal_words[1] = 32'h00221821;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         instruction = illegal_words[i];
         instr_valid = 1'b1;
         @(negedge clk);
         checkOutput("ill_ready_idle", 32'(instr_ready), 32'd1);
         @(posedge clk); #1;
         instr_valid = 1'b0;
         @(negedge clk);
         checkOutput("illegal_pulse", 32'(illegal), 32'd1);
         checkOutput("ill_ready_decode", 32'(instr_ready), 32'd0);
         @(negedge clk);
         checkOutput("illegal_clear", 32'(illegal), 32'd0);
         checkOutput("ill_ready_after", 32'(instr_ready), 32'd1);
      end
      checkRetired("retired_illegal");

      regs[1] = 32'd5;
      regs[2] = 32'd7;
      applyStimulus(32'h00220020, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("rd0_ready", 32'(instr_ready), 32'd1);
      checkRetired("retired_rd0");

      @(posedge clk); #1;
      instruction = 32'h00223020;
      instr_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("arst_we", 32'(write_enable), 32'd0);
      checkOutput("arst_ready", 32'(instr_ready), 32'd1);
      checkOutput("arst_raddr1", 32'(read_address_1), 32'd0);
      checkOutput("arst_raddr2", 32'(read_address_2), 32'd0);
      checkOutput("arst_waddr", 32'(write_address), 32'd0);
      checkOutput("arst_wdata", data_write, 32'd0);
      retired_model = 0;
      checkRetired("arst_retired");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      regs[1] = 32'd5;
      regs[2] = 32'd7;
      applyStimulus(32'h00223020, 1'b0, 1'b0);
      waitDrain();

      regs[1] = $urandom;
      regs[2] = $urandom;
      words[0] = 32'h00221820;
      words[1] = 32'h00222022;
      words[2] = 32'h0022282A;
      words[3] = 32'h00223824;
      for (int i = 0; i < 4; i++) applyStimulus(words[i], (i < 3), (i > 0));
      waitDrain();
      checkRetired("retired_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
